// File: rtl/fpu_iter_pipe.sv
// fpu_iter_pipe: handshaked add/sub/mul/div FPU, round-toward-zero.
// Subnormals read as zero; division retires one quotient bit per cycle.
module fpu_iter_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_op,
  input  logic [EXP_W+MAN_W:0] in_a,
  input  logic [EXP_W+MAN_W:0] in_b,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_result,
  output logic [3:0]           out_flags,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 busy
);
  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int BIAS   = (1 << (EXP_W - 1)) - 1;
  localparam int DIV_IT = MAN_W + 2;
  localparam int EMAX   = (1 << EXP_W) - 1;
  localparam int MW     = MAN_W + 1;
  localparam int AW     = MAN_W + 4;
  localparam int XW     = EXP_W + 2;
  localparam int CW     = $clog2(DIV_IT);

  typedef logic signed [XW-1:0] sexp_t;
  typedef enum logic [1:0] {IDLE, CALC, DIV, DONE} state_t;

  localparam logic [W-1:0] QNAN =
    {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  function automatic logic [W-1:0] inf_of(input logic s);
    return {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  endfunction

  // Returns {overflow, underflow, result}.
  function automatic logic [W+1:0] pack(
    input logic               s,
    input sexp_t              e,
    input logic [MAN_W-1:0]   f
  );
    if (e >= sexp_t'(EMAX)) return {2'b10, inf_of(s)};
    if (e <= sexp_t'(0)) return {2'b01, s, {(W-1){1'b0}}};
    return {2'b00, s, EXP_W'(e), f};
  endfunction

  function automatic int lzc(input logic [AW-1:0] v);
    int n;
    n = AW;
    for (int i = 0; i < AW; i++)
      if (v[i]) n = AW - 1 - i;
    return n;
  endfunction

  state_t           r_state, w_next;
  logic [1:0]       r_op;
  logic [W-1:0]     r_a, r_b, r_res;
  logic [3:0]       r_flags;
  logic [TAG_W-1:0] r_tag;
  logic [MW:0]      r_rem;
  logic [MAN_W:0]   r_quo;
  logic [CW-1:0]    r_cnt;

  logic             w_sa, w_sb, w_sbe, w_ms;
  logic [EXP_W-1:0] w_ea, w_eb;
  logic [MW-1:0]    w_ma, w_mb;
  logic             w_za, w_zb, w_ia, w_ib, w_na, w_nb;

  assign w_sa  = r_a[W-1];
  assign w_sb  = r_b[W-1];
  assign w_ea  = r_a[W-2:MAN_W];
  assign w_eb  = r_b[W-2:MAN_W];
  assign w_ma  = {1'b1, r_a[MAN_W-1:0]};
  assign w_mb  = {1'b1, r_b[MAN_W-1:0]};
  assign w_za  = (w_ea == '0);
  assign w_zb  = (w_eb == '0);
  assign w_ia  = (&w_ea) && (r_a[MAN_W-1:0] == '0);
  assign w_ib  = (&w_eb) && (r_b[MAN_W-1:0] == '0);
  assign w_na  = (&w_ea) && (|r_a[MAN_W-1:0]);
  assign w_nb  = (&w_eb) && (|r_b[MAN_W-1:0]);
  assign w_sbe = w_sb ^ (r_op == 2'b01);
  assign w_ms  = w_sa ^ w_sb;

  logic             w_swap, w_xs, w_eff_sub;
  logic [EXP_W-1:0] w_xe, w_ye, w_diff;
  logic [MW-1:0]    w_xm, w_ym;
  logic [2*AW-1:0]  w_ywide;
  logic [AW-1:0]    w_yal, w_norm;
  logic [AW:0]      w_sum;
  int               w_sh, w_lz;
  sexp_t            w_aexp, w_mexp, w_dexp;
  logic [W+1:0]     w_add_pk, w_mul_pk, w_div_pk;
  logic [2*MW-1:0]  w_prod;
  logic             w_ge;
  logic [MW:0]      w_rsub, w_rem_n, w_quo_n;

  // Datapaths: aligned add with guard/round/sticky, mul, one divide step.
  always_comb begin
    w_swap = r_b[W-2:0] > r_a[W-2:0];
    w_xs   = w_swap ? w_sbe : w_sa;
    w_xe   = w_swap ? w_eb : w_ea;
    w_ye   = w_swap ? w_ea : w_eb;
    w_xm   = w_swap ? w_mb : w_ma;
    w_ym   = w_swap ? w_ma : w_mb;
    w_diff = w_xe - w_ye;
    w_sh   = (int'(w_diff) > AW) ? AW : int'(w_diff);
    w_ywide = {w_ym, 3'b000, {AW{1'b0}}} >> w_sh;
    w_yal  = w_ywide[2*AW-1:AW] | AW'(|w_ywide[AW-1:0]);
    w_eff_sub = (w_sa != w_sbe);
    w_sum  = w_eff_sub ? {1'b0, w_xm, 3'b000} - {1'b0, w_yal}
                       : {1'b0, w_xm, 3'b000} + {1'b0, w_yal};
    w_lz   = 0;
    if (w_sum[AW]) begin
      w_norm = AW'(w_sum >> 1) | AW'(w_sum[0]);
      w_aexp = sexp_t'(w_xe) + sexp_t'(1);
    end else begin
      w_lz   = lzc(AW'(w_sum));
      w_norm = AW'(w_sum) << w_lz;
      w_aexp = sexp_t'(w_xe) - sexp_t'(w_lz);
    end
    w_add_pk = pack(w_xs, w_aexp, MAN_W'(w_norm >> 3));

    w_prod = {{MW{1'b0}}, w_ma} * {{MW{1'b0}}, w_mb};
    w_mexp = sexp_t'(w_ea) + sexp_t'(w_eb) - sexp_t'(BIAS)
           + sexp_t'(w_prod[2*MW-1]);
    w_mul_pk = pack(w_ms, w_mexp,
      w_prod[2*MW-1] ? MAN_W'(w_prod >> MW)
                     : MAN_W'(w_prod >> (MW-1)));

    w_dexp = sexp_t'(w_ea) - sexp_t'(w_eb) + sexp_t'(BIAS)
           - sexp_t'(w_ma < w_mb);
    w_ge    = r_rem >= {1'b0, w_mb};
    w_rsub  = w_ge ? r_rem - {1'b0, w_mb} : r_rem;
    w_rem_n = w_rsub << 1;
    w_quo_n = {r_quo, w_ge};
    w_div_pk = pack(w_ms, w_dexp,
      w_quo_n[MW] ? MAN_W'(w_quo_n >> 1) : MAN_W'(w_quo_n));
  end

  logic [W-1:0] w_res;
  logic [3:0]   w_flg;
  logic         w_go_div;

  always_comb begin
    w_res    = '0;
    w_flg    = '0;
    w_go_div = 1'b0;
    if (w_na || w_nb) begin
      w_res = QNAN;
    end else begin
      case (r_op)
        2'b10: begin
          if ((w_za && w_ib) || (w_ia && w_zb)) begin
            w_res = QNAN;
            w_flg = 4'b1000;
          end else if (w_ia || w_ib) begin
            w_res = inf_of(w_ms);
          end else if (w_za || w_zb) begin
            w_res = {w_ms, {(W-1){1'b0}}};
          end else begin
            w_res = w_mul_pk[W-1:0];
            w_flg = {2'b00, w_mul_pk[W+1:W]};
          end
        end
        2'b11: begin
          if ((w_za && w_zb) || (w_ia && w_ib)) begin
            w_res = QNAN;
            w_flg = 4'b1000;
          end else if (w_ia) begin
            w_res = inf_of(w_ms);
          end else if (w_ib || w_za) begin
            w_res = {w_ms, {(W-1){1'b0}}};
          end else if (w_zb) begin
            w_res = inf_of(w_ms);
            w_flg = 4'b0100;
          end else begin
            w_go_div = 1'b1;
          end
        end
        default: begin
          if (w_ia && w_ib && (w_sa != w_sbe)) begin
            w_res = QNAN;
            w_flg = 4'b1000;
          end else if (w_ia) begin
            w_res = inf_of(w_sa);
          end else if (w_ib) begin
            w_res = inf_of(w_sbe);
          end else if (w_za && w_zb) begin
            w_res = {w_sa & w_sbe, {(W-1){1'b0}}};
          end else if (w_za) begin
            w_res = {w_sbe, r_b[W-2:0]};
          end else if (w_zb) begin
            w_res = r_a;
          end else if (w_sum == '0) begin
            w_res = '0;
          end else begin
            w_res = w_add_pk[W-1:0];
            w_flg = {2'b00, w_add_pk[W+1:W]};
          end
        end
      endcase
    end
  end

  logic w_last;
  assign w_last = (r_cnt == CW'(DIV_IT - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (in_valid) w_next = CALC;
      CALC: w_next = w_go_div ? DIV : DONE;
      DIV:  if (w_last) w_next = DONE;
      DONE: if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_tag   <= '0;
      r_res   <= '0;
      r_flags <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_cnt   <= '0;
    end else begin
      if (in_valid && in_ready) begin
        r_op  <= in_op;
        r_a   <= in_a;
        r_b   <= in_b;
        r_tag <= in_tag;
      end
      if (r_state == CALC) begin
        if (w_go_div) begin
          r_rem <= {1'b0, w_ma};
          r_quo <= '0;
          r_cnt <= '0;
        end else begin
          r_res   <= w_res;
          r_flags <= w_flg;
        end
      end
      if (r_state == DIV) begin
        r_rem <= w_rem_n;
        r_quo <= w_quo_n[MAN_W:0];
        r_cnt <= r_cnt + CW'(1);
        if (w_last) begin
          r_res   <= w_div_pk[W-1:0];
          r_flags <= {2'b00, w_div_pk[W+1:W]};
        end
      end
    end
  end

  assign in_ready   = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign out_valid  = (r_state == DONE);
  assign out_result = r_res;
  assign out_flags  = r_flags;
  assign out_tag    = r_tag;
endmodule

// File: tb/tb_fpu_iter_pipe.sv
// Directed bench for fpu_iter_pipe: single-precision and half-precision
// builds, hand-computed results, latency, back-pressure and reset abort.
module tb_fpu_iter_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = '0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [3:0]  out_flags;
  logic [3:0]  out_tag;
  logic        busy;

  logic        h_in_valid = 1'b0;
  logic        h_in_ready;
  logic [1:0]  h_in_op = '0;
  logic [15:0] h_in_a = '0;
  logic [15:0] h_in_b = '0;
  logic [3:0]  h_in_tag = '0;
  logic        h_out_valid;
  logic        h_out_ready = 1'b0;
  logic [15:0] h_out_result;
  logic [3:0]  h_out_flags;
  logic [3:0]  h_out_tag;
  logic        h_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpu_iter_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags),
    .out_tag(out_tag), .busy(busy)
  );

  fpu_iter_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) dut_h (
    .clk(clk), .rst(rst),
    .in_valid(h_in_valid), .in_ready(h_in_ready), .in_op(h_in_op),
    .in_a(h_in_a), .in_b(h_in_b), .in_tag(h_in_tag),
    .out_valid(h_out_valid), .out_ready(h_out_ready),
    .out_result(h_out_result), .out_flags(h_out_flags),
    .out_tag(h_out_tag), .busy(h_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input string nm, input logic [1:0] op,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] tg, input logic [31:0] er,
                     input logic [3:0] ef, input int elat,
                     input int hold);
    int lat;
    int hi;
    @(negedge clk);
    chk({nm, "_acc_rdy"}, in_ready, 1);
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    in_tag = tg;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    hi = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (in_ready) hi++;
    end
    chk({nm, "_lat"}, lat, elat);
    chk({nm, "_rdy_low"}, hi, 0);
    chk({nm, "_res"}, out_result, er);
    chk({nm, "_flags"}, out_flags, ef);
    chk({nm, "_tag"}, out_tag, tg);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({nm, "_hold_v"}, out_valid, 1);
      chk({nm, "_hold_res"}, out_result, er);
      chk({nm, "_hold_flg"}, out_flags, ef);
      chk({nm, "_hold_tag"}, out_tag, tg);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({nm, "_ret_rdy"}, in_ready, 1);
    chk({nm, "_ret_v"}, out_valid, 0);
  endtask

  task automatic h_run(input string nm, input logic [1:0] op,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] er);
    @(negedge clk);
    h_in_valid = 1'b1;
    h_in_op = op;
    h_in_a = a;
    h_in_b = b;
    h_in_tag = 4'h3;
    @(posedge clk);
    #1;
    h_in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk({nm, "_v"}, h_out_valid, 1);
    chk({nm, "_res"}, h_out_result, er);
    chk({nm, "_flags"}, h_out_flags, 0);
    h_out_ready = 1'b1;
    @(posedge clk);
    #1;
    h_out_ready = 1'b0;
    chk({nm, "_ret_rdy"}, h_in_ready, 1);
  endtask

  initial begin
    int seen;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", out_result, 0);
    chk("rst_flags", out_flags, 0);
    chk("rst_tag", out_tag, 0);
    rst = 1'b0;

    run("add", 2'b00, 32'h3FC00000, 32'h40100000, 4'h5,
        32'h40700000, 4'b0000, 1, 0);
    run("sub_cancel", 2'b01, 32'h3F800000, 32'h3F800000, 4'h1,
        32'h00000000, 4'b0000, 1, 0);
    run("inf_inf", 2'b00, 32'hFF800000, 32'h7F800000, 4'h2,
        32'h7FC00000, 4'b1000, 1, 0);
    run("neg_zeros", 2'b00, 32'h80000000, 32'h80000000, 4'h3,
        32'h80000000, 4'b0000, 1, 0);
    run("nan_in", 2'b00, 32'h7FC00001, 32'h3F800000, 4'h4,
        32'h7FC00000, 4'b0000, 1, 0);
    run("sub_sticky", 2'b01, 32'h3F800000, 32'h30800000, 4'h6,
        32'h3F7FFFFF, 4'b0000, 1, 0);
    run("mul_ovf", 2'b10, 32'h7F000000, 32'h40000000, 4'h7,
        32'h7F800000, 4'b0010, 1, 0);
    run("mul_unf", 2'b10, 32'h00800000, 32'h00800000, 4'h8,
        32'h00000000, 4'b0001, 1, 0);
    run("div_6_2", 2'b11, 32'h40C00000, 32'h40000000, 4'h9,
        32'h40400000, 4'b0000, 26, 0);
    run("div_1_3", 2'b11, 32'h3F800000, 32'h40400000, 4'hB,
        32'h3EAAAAAA, 4'b0000, 26, 0);
    run("div_0_0", 2'b11, 32'h00000000, 32'h00000000, 4'hC,
        32'h7FC00000, 4'b1000, 1, 0);
    run("div_by_0", 2'b11, 32'hBF800000, 32'h00000000, 4'hD,
        32'hFF800000, 4'b0100, 1, 0);
    run("mul_hold", 2'b10, 32'h40000000, 32'h40400000, 4'hA,
        32'h40C00000, 4'b0000, 1, 5);

    @(negedge clk);
    in_valid = 1'b1;
    in_op = 2'b11;
    in_a = 32'h40C00000;
    in_b = 32'h40000000;
    in_tag = 4'hE;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    chk("abort_pre_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_tag", out_tag, 0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("abort_no_result", seen, 0);

    h_run("h_add", 2'b00, 16'h3C00, 16'h3C00, 16'h4000);
    h_run("h_mul", 2'b10, 16'h4000, 16'h4200, 16'h4600);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fpu_iter_pipe.md
Name: fpu_iter_pipe

Overview:
- Parametrised, handshaked floating-point unit for add, subtract, multiply and divide.
- Successor to the single-cycle 32-bit FPU: format width is generic, division is iterative (one quotient bit per cycle) and valid/ready handshakes sit on both sides.
- Adds IEEE-style exception flags and a pass-through tag.
- Sits between the operand scheduler and the result writeback queue.

Parameters:
- EXP_W, 8, exponent field width (>=4).
- MAN_W, 23, stored mantissa (fraction) width (>=4).
- TAG_W, 4, width of the opaque tag carried from input to output.
- Derived (localparam):
  - W = 1+EXP_W+MAN_W.
  - BIAS = 2^(EXP_W-1)-1.
  - DIV_IT = MAN_W+2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand request valid
- in_ready  out  1  unit can accept (high only in IDLE)
- in_op  in  2  00 add, 01 sub (a-b), 10 mul, 11 div (a/b)
- in_a  in  W  operand a
- in_b  in  W  operand b
- in_tag  in  TAG_W  opaque tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_result  out  W  result
- out_flags  out  4  {invalid, div_by_zero, overflow, underflow}
- out_tag  out  TAG_W  tag of this result
- busy  out  1  state != IDLE

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - On reset: state=IDLE, in_ready=1, out_valid=0, busy=0.
  - out_result, out_flags and out_tag reset to 0.
  - rst mid-operation abandons the operation; no result is produced.
- FSM states: IDLE, CALC, DIV, DONE.
  - IDLE: accept when in_valid&&in_ready at an edge (edge 0). Operands, op and tag are registered; go to CALC.
  - CALC: special cases and add/sub/mul compute; result registered; go to DONE (out_valid high after edge 1).
    - div with finite nonzero operands: initialise the divider and go to DIV instead.
  - DIV: restoring division, one quotient bit per edge, exactly DIV_IT iterations. The last iteration edge normalises and registers the result, then goes to DONE. out_valid rises at edge DIV_IT+1, i.e. edge 26 for the single-precision default.
  - DONE: hold out_* stable while out_ready=0; on out_valid&&out_ready go to IDLE.
    - in_ready stays low in DONE, so no same-edge reaccept.
    - Maximum throughput is one op per 3 cycles (non-div).
- Number handling:
  - Subnormal inputs are treated as signed zero; subnormal results flush to signed zero.
  - Rounding is round-toward-zero (truncation).
  - Add/sub alignment keeps guard, round and sticky bits, so truncation is exact RTZ.
  - Alignment shifts >= MAN_W+3 collapse into sticky.
- Add/sub:
  - sub = add with b sign inverted.
  - Exact cancellation gives +0.
  - Normalisation: carry-out shifts right by one and increments the exponent; leading-zero count shifts left.
  - If the exponent would drop below 1, the result is a signed zero with the underflow flag.
- Mul:
  - exp = ea+eb-BIAS+carry, computed with EXP_W+2-bit signed intermediate.
  - Product is (MAN_W+1)x(MAN_W+1), truncated.
- Div:
  - exp = ea-eb+BIAS, minus 1 if mant_a<mant_b (normalisation).
  - Quotient is truncated.
- Overflow (exp >= 2^EXP_W-1): result is signed infinity; set overflow.
- Underflow (exp <= 0): result is signed zero; set underflow.
- Specials (all ops, resolved in CALC):
  - Any NaN input gives canonical qNaN {0, all-ones exp, fraction MSB=1}. No invalid flag is set for this case.
  - The following give qNaN with invalid set: inf-inf (effective subtraction), 0*inf, 0/0, inf/inf.
  - x/0 with x finite nonzero gives signed inf with div_by_zero set.
  - Any other infinity operand gives the IEEE-signed infinity or zero.
  - Zero results carry sign xor (mul/div); for add, -0 + -0 = -0.
- out_flags and out_tag are valid exactly while out_valid=1.

Test Plan:
1. Reset, then add 0x3FC00000 + 0x40100000, tag 5 -> out_valid at edge 1, out_result 0x40700000, flags 0000, out_tag 5; in_ready back high the cycle after the out handshake.
2. sub 0x3F800000 - 0x3F800000 -> 0x00000000. Add 0xFF800000 + 0x7F800000 -> 0x7FC00000 with invalid=1.
3. mul 0x7F000000 * 0x40000000 -> 0x7F800000 with overflow=1. mul 0x00800000 * 0x00800000 -> 0x00000000 with underflow=1.
4. div 0x40C00000 / 0x40000000 -> 0x40400000 at exactly edge 26, in_ready=0 for edges 1..26. div 0x3F800000 / 0x40400000 -> 0x3EAAAAAA (truncated).
5. div 0x00000000 / 0x00000000 -> 0x7FC00000 with invalid=1. div 0xBF800000 / 0x00000000 -> 0xFF800000 with div_by_zero=1, at edge 1.
6. Hold out_ready=0 for 5 cycles -> result, flags and tag stable. Assert rst at DIV iteration 10 -> out_valid=0 and in_ready=1 after that edge. Half-precision build (EXP_W=5, MAN_W=10): 0x3C00 + 0x3C00 -> 0x4000.
